// File: rtl/hazard_stall_unit_if.sv
// Pipeline-facing bundle of the hazard/stall unit: ID/EX hazard inputs, register
// enables toward the pipeline and the MEM/WB destination scoreboard.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             branch_taken;
    // Handshake: the access held in stage 4 (mem_access_q inside the unit) is the
    // valid side and dmem_ready is ready; the access completes, and the pipeline
    // advances, only on a cycle where both are high. Without a pending access,
    // dmem_ready is ignored.
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             memwb_bubble;
    logic [4:0]       mem_stage_rd;
    logic             mem_stage_rw;
    logic [4:0]       wb_stage_rd;
    logic             wb_stage_rw;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic             in_mem_wait;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, branch_taken, dmem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               memwb_bubble, mem_stage_rd, mem_stage_rw, wb_stage_rd,
               wb_stage_rw, mem_timeout, stall_cycles, in_mem_wait
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, branch_taken, dmem_ready,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
               memwb_bubble, mem_stage_rd, mem_stage_rw, wb_stage_rd,
               wb_stage_rw, mem_timeout, stall_cycles, in_mem_wait
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for load-use hazards, taken branches and slow data
// memory, plus the MEM/WB destination scoreboard used by the forwarding unit.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int              WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_MAX  = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t           state, state_d;
    logic [WCW-1:0]   wait_cnt, wait_cnt_d;
    logic             mem_access_q;
    logic             idex_bubble_prev;
    logic [4:0]       mem_rd_q, wb_rd_q;
    logic             mem_rw_q, wb_rw_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;

    logic lu, busy;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, memwb_bubble;

    assign busy = mem_access_q & ~hz.dmem_ready;
    assign lu   = hz.ex_mem_read & hz.ex_reg_write & (hz.ex_rd != 5'd0) &
                  ((hz.id_uses_rs & (hz.ex_rd == hz.id_rs)) |
                   (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));

    // Outputs are forced low while reset is held so the pipeline never moves in reset.
    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_freeze  = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            if (busy) begin
                pipe_freeze  = 1'b1;
                memwb_bubble = 1'b1;
            end else if (hz.branch_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (lu) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
        case (state)
            RUN: begin
                if (busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (!busy) begin
                    state_d = RUN;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= RUN;
            wait_cnt         <= '0;
            mem_access_q     <= 1'b0;
            idex_bubble_prev <= 1'b0;
            mem_rd_q         <= 5'd0;
            mem_rw_q         <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_rw_q          <= 1'b0;
            timeout_q        <= 1'b0;
            stall_q          <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (state_d == MEM_WAIT && wait_cnt_d == WAIT_LAST) begin
                timeout_q <= 1'b1;
            end
            // A frozen pipeline keeps the bubble marker: EX still holds the same NOP.
            if (!busy) begin
                mem_access_q     <= (hz.ex_mem_read | hz.ex_mem_write) & ~idex_bubble_prev;
                idex_bubble_prev <= idex_bubble;
                mem_rd_q         <= idex_bubble_prev ? 5'd0 : hz.ex_rd;
                mem_rw_q         <= ~idex_bubble_prev & hz.ex_reg_write & (hz.ex_rd != 5'd0);
                wb_rd_q          <= mem_rd_q;
                wb_rw_q          <= mem_rw_q;
            end else begin
                wb_rd_q <= 5'd0;
                wb_rw_q <= 1'b0;
            end
            if (!pc_write && stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.pipe_freeze  = pipe_freeze;
    assign hz.memwb_bubble = memwb_bubble;
    assign hz.mem_stage_rd = mem_rd_q;
    assign hz.mem_stage_rw = mem_rw_q;
    assign hz.wb_stage_rd  = wb_rd_q;
    assign hz.wb_stage_rw  = wb_rw_q;
    assign hz.mem_timeout  = timeout_q;
    assign hz.stall_cycles = stall_q;
    assign hz.in_mem_wait  = (state == MEM_WAIT);
endmodule
